// File: rtl/aes_round_sequencer.sv
// Control sequencer for the AES round datapath: round-0 key add, per-round key generation and
// column stepping for AES-128/192/256, with optional decrypt-key pre-expansion and output hold.
module aes_round_sequencer #(
  parameter int unsigned NCOL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       start_ready,
  input  logic       op_dec,
  input  logic [1:0] key_len,
  input  logic       key_cached,
  input  logic       abort,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       err,
  output logic       key_exp_en,
  output logic       key_gen,
  output logic [3:0] col_en,
  output logic [1:0] col_idx,
  output logic       bypass_rk,
  output logic       last_round,
  output logic [3:0] round,
  output logic       enc_dec
);

  if (!((NCOL == 1) || (NCOL == 2) || (NCOL == 4))) begin : g_bad_ncol
    $error("NCOL must be 1, 2 or 4");
  end

  localparam int unsigned ColSteps = 4 / NCOL;
  localparam int unsigned NcolLog2 = $clog2(NCOL);
  localparam logic [1:0]  SLast    = 2'(ColSteps - 1);
  localparam logic [3:0]  ColMask  = 4'((1 << NCOL) - 1);

  typedef enum logic [2:0] {StIdle, StKeyExp, StRound0, StKey, StRound, StHold} state_e;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] s_q, s_d;
  logic [1:0] klen_q, klen_d;
  logic       enc_q, enc_d;
  logic       err_q, err_d;
  logic [3:0] nr;
  logic [1:0] step;
  logic       accept, illegal, pre_exp;

  always_comb begin
    case (klen_q)
      2'b00:   nr = 4'd10;
      2'b01:   nr = 4'd12;
      default: nr = 4'd14;
    endcase
  end

  assign start_ready = (state_q == StIdle) | ((state_q == StHold) & out_ready);
  assign accept      = start & start_ready & ~abort & (key_len != 2'b11);
  assign illegal     = start & start_ready & ~abort & (key_len == 2'b11);
  assign pre_exp     = op_dec & ~key_cached;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      s_q     <= 2'd0;
      klen_q  <= 2'd0;
      enc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      s_q     <= s_d;
      klen_q  <= klen_d;
      enc_q   <= enc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    s_d     = s_q;
    klen_d  = klen_q;
    enc_d   = enc_q;
    err_d   = illegal;
    if (abort) begin
      state_d = StIdle;
      round_d = 4'd0;
      s_d     = 2'd0;
      enc_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StKeyExp: begin
          if (round_q == nr) begin
            state_d = StRound0;
            round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
        StRound0: begin
          s_d = s_q + 2'd1;
          if (s_q == SLast) begin
            s_d     = 2'd0;
            state_d = StKey;
          end
        end
        StKey: begin
          round_d = round_q + 4'd1;
          state_d = StRound;
        end
        StRound: begin
          s_d = s_q + 2'd1;
          if (s_q == SLast) begin
            s_d     = 2'd0;
            state_d = (round_q == nr) ? StHold : StKey;
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StIdle;
            round_d = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
      // Acceptance also covers the HOLD handshake, so back-to-back starts skip IDLE.
      if (accept) begin
        state_d = pre_exp ? StKeyExp : StRound0;
        round_d = pre_exp ? 4'd1 : 4'd0;
        s_d     = 2'd0;
        klen_d  = key_len;
        enc_d   = ~op_dec;
      end
    end
  end

  always_comb begin
    step       = enc_q ? s_q : (SLast - s_q);
    out_valid  = (state_q == StHold);
    key_exp_en = (state_q == StKeyExp);
    key_gen    = (state_q == StKey);
    bypass_rk  = (state_q == StRound0);
    last_round = ((state_q == StKey) | (state_q == StRound)) & (round_q == nr);
    round      = round_q;
    enc_dec    = enc_q;
    err        = err_q;
    col_idx    = 2'b00;
    col_en     = 4'b0000;
    if ((state_q == StRound0) | (state_q == StRound)) begin
      col_idx = step << NcolLog2;
      col_en  = ColMask << col_idx;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Drives NCOL=1/2/4 sequencers in lockstep and checks every cycle against a schedule model
// built from the round structure (key expansion, round 0, Nr x (key + column steps), hold).
module tb_aes_round_sequencer;

  typedef struct packed {
    logic       start_ready;
    logic       out_valid;
    logic       err;
    logic       key_exp_en;
    logic       key_gen;
    logic       bypass_rk;
    logic       last_round;
    logic       enc_dec;
    logic [3:0] round;
    logic [1:0] col_idx;
    logic [3:0] col_en;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n, start, op_dec, key_cached, abort, out_ready;
  logic [1:0] key_len;
  logic       sr [3];
  logic       ov [3];
  logic       er [3];
  logic       kx [3];
  logic       kg [3];
  logic       bp [3];
  logic       lr [3];
  logic       ed [3];
  logic [3:0] ce [3];
  logic [3:0] rd [3];
  logic [1:0] ci [3];

  obs_t exp_q [3][$];
  obs_t hold_rec [3];
  int   exp_lat [3];
  int   n_tests, n_fail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_sequencer #(.NCOL(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_ready(sr[g]),
      .op_dec     (op_dec),
      .key_len    (key_len),
      .key_cached (key_cached),
      .abort      (abort),
      .out_ready  (out_ready),
      .out_valid  (ov[g]),
      .err        (er[g]),
      .key_exp_en (kx[g]),
      .key_gen    (kg[g]),
      .col_en     (ce[g]),
      .col_idx    (ci[g]),
      .bypass_rk  (bp[g]),
      .last_round (lr[g]),
      .round      (rd[g]),
      .enc_dec    (ed[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe(input int g);
    obs_t o;
    o.start_ready = sr[g];
    o.out_valid   = ov[g];
    o.err         = er[g];
    o.key_exp_en  = kx[g];
    o.key_gen     = kg[g];
    o.bypass_rk   = bp[g];
    o.last_round  = lr[g];
    o.enc_dec     = ed[g];
    o.round       = rd[g];
    o.col_idx     = ci[g];
    o.col_en      = ce[g];
    return o;
  endfunction

  function automatic obs_t idle_rec(input logic enc);
    obs_t o = '0;
    o.start_ready = 1'b1;
    o.enc_dec     = enc;
    return o;
  endfunction

  function automatic obs_t col_rec(input bit dec, input int nc, input int s, input int r,
                                   input bit last, input bit byp);
    obs_t o = '0;
    int   idx;
    idx          = (dec ? (4 / nc - 1 - s) : s) * nc;
    o.enc_dec    = !dec;
    o.bypass_rk  = byp;
    o.last_round = last;
    o.round      = 4'(r);
    o.col_idx    = 2'(idx);
    o.col_en     = 4'(((1 << nc) - 1) << idx);
    return o;
  endfunction

  // Expected per-cycle schedule for one operation on the NCOL = 1<<g instance.
  task automatic build(input int g, input bit dec, input int kl, input bit cached);
    int   nc = 1 << g;
    int   cs = 4 / nc;
    int   nr = 10 + 2 * kl;
    obs_t o;
    exp_q[g].delete();
    if (dec && !cached) begin
      for (int r = 1; r <= nr; r++) begin
        o = '0; o.enc_dec = !dec; o.key_exp_en = 1'b1; o.round = 4'(r);
        exp_q[g].push_back(o);
      end
    end
    for (int s = 0; s < cs; s++) exp_q[g].push_back(col_rec(dec, nc, s, 0, 1'b0, 1'b1));
    for (int r = 1; r <= nr; r++) begin
      o = '0; o.enc_dec = !dec; o.key_gen = 1'b1; o.round = 4'(r - 1);
      exp_q[g].push_back(o);
      for (int s = 0; s < cs; s++) exp_q[g].push_back(col_rec(dec, nc, s, r, r == nr, 1'b0));
    end
    o = '0; o.out_valid = 1'b1; o.round = 4'(nr); o.enc_dec = !dec;
    hold_rec[g] = o;
    exp_lat[g]  = ((dec && !cached) ? nr : 0) + cs + nr * (1 + cs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input obs_t e);
    for (int g = 0; g < 3; g++)
      chk($sformatf("%s n%0d", tag, 1 << g), {14'd0, observe(g)}, {14'd0, e});
  endtask

  task automatic launch(input bit dec, input int kl, input bit cached);
    op_dec = dec; key_len = 2'(kl); key_cached = cached; start = 1'b1;
    for (int g = 0; g < 3; g++) build(g, dec, kl, cached);
    step();
    start = 1'b0; out_ready = 1'b0;
  endtask

  // Walks the schedule; optional abort or async reset at trace cycle abort_at / reset_at.
  task automatic run_trace(input int abort_at, input int reset_at);
    bit   seen [3];
    obs_t e;
    int   i = 0;
    for (int g = 0; g < 3; g++) seen[g] = 1'b0;
    forever begin
      if (i >= 200) begin
        chk("trace timeout", 32'd0, 32'd1);
        break;
      end
      for (int g = 0; g < 3; g++) begin
        if (exp_q[g].size() > 0) e = exp_q[g].pop_front();
        else e = hold_rec[g];
        chk($sformatf("trace c%0d n%0d", i, 1 << g), {14'd0, observe(g)}, {14'd0, e});
        if (!seen[g] && ov[g]) begin
          seen[g] = 1'b1;
          chk($sformatf("latency n%0d", 1 << g), 32'(i), 32'(exp_lat[g]));
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
      if (i == abort_at) begin
        abort = 1'b1; start = 1'(($urandom % 2));
        step();
        abort = 1'b0; start = 1'b0;
        chk_all("abort", idle_rec(1'b0));
        break;
      end
      if (i == reset_at) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all("async reset", idle_rec(1'b0));
        #4 rst_n = 1'b1;
        step();
        chk_all("post reset", idle_rec(1'b0));
        break;
      end
      start      = ($urandom % 4) == 0;
      key_len    = 2'($urandom);
      op_dec     = 1'($urandom);
      key_cached = 1'($urandom);
      step();
      i++;
    end
    start = 1'b0;
    for (int g = 0; g < 3; g++) exp_q[g].delete();
  endtask

  initial begin
    bit   b2b, dec, cached;
    int   kl, nh;
    obs_t e;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; op_dec = 1'b0; key_len = 2'd0; key_cached = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    #12;
    chk_all("reset", idle_rec(1'b0));
    rst_n = 1'b1;
    step();

    key_len = 2'b11; start = 1'b1; op_dec = 1'b0;
    step();
    start = 1'b0; key_len = 2'b00;
    e = idle_rec(1'b0); e.err = 1'b1;
    chk_all("err pulse", e);
    step();
    chk_all("err clear", idle_rec(1'b0));

    b2b = 1'b0;
    for (int k = 0; k < 12; k++) begin
      case (k)
        0:       begin dec = 1'b0; kl = 0; cached = 1'b0; end
        1:       begin dec = 1'b0; kl = 2; cached = 1'b0; end
        2:       begin dec = 1'b1; kl = 1; cached = 1'b0; end
        3:       begin dec = 1'b0; kl = 0; cached = 1'b0; end
        default: begin dec = 1'($urandom); kl = $urandom % 3; cached = 1'($urandom); end
      endcase
      if (b2b) out_ready = 1'b1;
      launch(dec, kl, cached);
      run_trace(-1, -1);
      nh = (k == 0 || k == 2) ? 7 : $urandom_range(0, 3);
      for (int j = 0; j < nh; j++) begin
        step();
        for (int g = 0; g < 3; g++)
          chk($sformatf("hold n%0d", 1 << g), {14'd0, observe(g)}, {14'd0, hold_rec[g]});
      end
      b2b = (k == 2) ? 1'b1 : ((k >= 3 && k < 11) ? 1'($urandom) : 1'b0);
      if (!b2b) begin
        out_ready = 1'b1;
        step();
        chk_all("release", idle_rec(!dec));
        out_ready = 1'b0;
      end
    end

    launch(1'b0, 0, 1'b0);
    run_trace(20, -1);
    for (int j = 0; j < 5; j++) begin
      step();
      chk_all("post abort", idle_rec(1'b0));
    end

    op_dec = 1'b0; key_len = 2'd0; key_cached = 1'b0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_all("abort beats start", idle_rec(1'b0));
    step();
    chk_all("abort beats start idle", idle_rec(1'b0));

    launch(1'b0, 0, 1'b0);
    run_trace(-1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
